// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared state encodings and constants for the fetch stage
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        FE_BOOT    = 2'd0,
        FE_FETCH   = 2'd1,
        FE_HOLD    = 2'd2,
        FE_DISCARD = 2'd3
    } fe_state_t;

    // sll r0,r0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_skid.sv
// ============================================================================
// fetch_skid : one-entry {instr,pc} holding register for a read that
//              completes while decode is stalled
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fetch_skid #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 28
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   load,
    input  logic                   clear,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic [PC_WIDTH-1:0]    pc_in,
    output logic                   full,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc
);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// ============================================================================
// fetch : MIPS fetch stage - owns the PC, reads imem over req/ack and hands
//         {instruction, pc} to decode with stall, redirect and kill support
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fetch
    import fetch_pkg::*;
#(
    parameter int                 INSTR_WIDTH = 32,
    parameter int                 PC_WIDTH    = 28,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEFAULT[INSTR_WIDTH-1:0]
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_en,
    input  logic                   i_jmp_en,
    input  logic [PC_WIDTH-1:0]    i_pc_jmp,
    input  logic                   i_fe_kill,
    output logic                   o_imem_req,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [PC_WIDTH-1:0]    o_pc_fe,
    output logic [PC_WIDTH-1:0]    o_pc_fe_de,
    output logic                   o_valid_fe
);

    fe_state_t             state;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   target;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic                  redirect;
    logic                  skid_load;
    logic                  skid_clear;
    logic                  skid_full;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]   skid_pc;

    // A jump seen during a stall is dropped; decode re-issues it once released.
    assign redirect   = i_fe_kill || (i_jmp_en && !i_stall_en);
    assign pc_inc     = pc + PC_WIDTH'(1);
    assign skid_load  = (state == FE_FETCH) && i_imem_ack && i_stall_en && !redirect;
    assign skid_clear = redirect || ((state == FE_HOLD) && !i_stall_en);

    fetch_skid #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .PC_WIDTH    (PC_WIDTH)
    ) u_skid (
        .clk      (i_clk),
        .arst     (i_arst),
        .load     (skid_load),
        .clear    (skid_clear),
        .instr_in (i_imem_rdata),
        .pc_in    (pc),
        .full     (skid_full),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state         <= FE_BOOT;
            pc            <= RESET_PC;
            target        <= '0;
            o_imem_req    <= 1'b0;
            o_imem_addr   <= RESET_PC;
            o_instruction <= NOP_INSTR;
            o_pc_fe       <= '0;
            o_pc_fe_de    <= '0;
            o_valid_fe    <= 1'b0;
        end else begin
            if (redirect) begin
                o_instruction <= NOP_INSTR;
                o_valid_fe    <= 1'b0;
            end
            case (state)
                FE_BOOT: begin
                    o_imem_req <= 1'b1;
                    state      <= FE_FETCH;
                    if (redirect) begin
                        pc          <= i_pc_jmp;
                        o_imem_addr <= i_pc_jmp;
                    end else begin
                        o_imem_addr <= pc;
                    end
                end
                FE_FETCH: begin
                    if (redirect) begin
                        // An unanswered read cannot be withdrawn; wait it out in DISCARD.
                        if (i_imem_ack) begin
                            pc          <= i_pc_jmp;
                            o_imem_addr <= i_pc_jmp;
                        end else begin
                            target <= i_pc_jmp;
                            state  <= FE_DISCARD;
                        end
                    end else if (i_imem_ack && !i_stall_en) begin
                        o_instruction <= i_imem_rdata;
                        o_pc_fe       <= pc_inc;
                        o_pc_fe_de    <= pc;
                        o_valid_fe    <= 1'b1;
                        pc            <= pc_inc;
                        o_imem_addr   <= pc_inc;
                    end else if (i_imem_ack) begin
                        o_imem_req <= 1'b0;
                        state      <= FE_HOLD;
                    end else if (!i_stall_en) begin
                        o_instruction <= NOP_INSTR;
                        o_valid_fe    <= 1'b0;
                    end
                end
                FE_HOLD: begin
                    if (redirect) begin
                        pc          <= i_pc_jmp;
                        o_imem_addr <= i_pc_jmp;
                        o_imem_req  <= 1'b1;
                        state       <= FE_FETCH;
                    end else if (!i_stall_en) begin
                        if (skid_full) begin
                            o_instruction <= skid_instr;
                            o_pc_fe       <= skid_pc + PC_WIDTH'(1);
                            o_pc_fe_de    <= skid_pc;
                            o_valid_fe    <= 1'b1;
                            pc            <= pc_inc;
                            o_imem_addr   <= pc_inc;
                        end else begin
                            o_instruction <= NOP_INSTR;
                            o_valid_fe    <= 1'b0;
                            o_imem_addr   <= pc;
                        end
                        o_imem_req <= 1'b1;
                        state      <= FE_FETCH;
                    end
                end
                FE_DISCARD: begin
                    if (i_imem_ack) begin
                        pc          <= redirect ? i_pc_jmp : target;
                        o_imem_addr <= redirect ? i_pc_jmp : target;
                        state       <= FE_FETCH;
                    end else if (redirect) begin
                        target <= i_pc_jmp;
                    end
                end
                default: begin
                    state <= FE_BOOT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ============================================================================
// tb_fetch : directed + randomized bench for fetch against a stream-level model
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_fetch;

    logic        clk;
    logic        arst;
    logic        stall_en;
    logic        jmp_en;
    logic [27:0] pc_jmp;
    logic        fe_kill;
    logic        imem_req;
    logic [27:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [27:0] pc_fe;
    logic [27:0] pc_fe_de;
    logic        valid_fe;

    int          checks;
    int          errors;
    int          deliveries;
    logic [27:0] exp_pc;
    bit          rand_mode;
    logic [27:0] slow_addr;
    int          slow_left;
    int          wait_left;

    fetch dut (
        .i_clk         (clk),
        .i_arst        (arst),
        .i_stall_en    (stall_en),
        .i_jmp_en      (jmp_en),
        .i_pc_jmp      (pc_jmp),
        .i_fe_kill     (fe_kill),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_rdata  (imem_rdata),
        .o_instruction (instruction),
        .o_pc_fe       (pc_fe),
        .o_pc_fe_de    (pc_fe_de),
        .o_valid_fe    (valid_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memf(input logic [27:0] a);
        return {2'b00, a, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory: answers the current request with addr*4 after an optional delay.
    task automatic mem_drive();
        imem_rdata = memf(imem_addr);
        if (!imem_req) begin
            imem_ack = 1'b0;
        end else if (imem_addr == slow_addr && slow_left > 0) begin
            imem_ack = 1'b0;
            slow_left--;
        end else if (rand_mode && wait_left > 0) begin
            imem_ack = 1'b0;
            wait_left--;
        end else begin
            imem_ack  = 1'b1;
            wait_left = rand_mode ? int'($urandom_range(0, 2)) : 0;
        end
    endtask

    // One clock: the model predicts the instruction stream decode should see.
    task automatic cycle();
        logic        p_stall, p_redir, p_req, p_ack;
        logic [27:0] p_tgt, p_addr, nxt;
        logic [88:0] p_out;
        p_stall = stall_en;
        p_redir = fe_kill || (jmp_en && !stall_en);
        p_tgt   = pc_jmp;
        p_req   = imem_req;
        p_ack   = imem_ack;
        p_addr  = imem_addr;
        p_out   = {instruction, pc_fe, pc_fe_de, valid_fe};
        @(posedge clk);
        #1;
        if (p_redir) begin
            chk("m_redir_bubble", {instruction, valid_fe}, {32'h0, 1'b0});
            exp_pc = p_tgt;
        end else if (p_stall) begin
            chk("m_stall_hold", {instruction, pc_fe, pc_fe_de, valid_fe}, p_out);
        end else if (valid_fe) begin
            nxt = exp_pc + 28'd1;
            chk("m_deliver", {instruction, pc_fe, pc_fe_de}, {memf(exp_pc), nxt, exp_pc});
            exp_pc = nxt;
            deliveries++;
        end else begin
            chk("m_bubble_nop", instruction, 32'h0);
        end
        if (p_req && !p_ack)
            chk("m_addr_stable", {imem_req, imem_addr}, {1'b1, p_addr});
        mem_drive();
    endtask

    task automatic run_until_addr(input logic [27:0] a);
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == a) break;
            cycle();
        end
        chk("reach_addr", {imem_req, imem_addr}, {1'b1, a});
    endtask

    initial begin
        checks = 0; errors = 0; deliveries = 0;
        exp_pc = '0; rand_mode = 0; slow_addr = '0; slow_left = 0; wait_left = 0;
        arst = 1; stall_en = 0; jmp_en = 0; fe_kill = 0; pc_jmp = '0;
        imem_ack = 0; imem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_outs", {instruction, pc_fe, pc_fe_de, valid_fe}, 0);
        arst = 0;
        mem_drive();

        // 1: zero-wait streaming from reset
        cycle();
        chk("t1_boot", {imem_req, imem_addr, valid_fe}, {1'b1, 28'd0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_stream", {valid_fe, pc_fe_de, pc_fe}, {1'b1, 28'(i), 28'(i + 1)});
        end

        // 2: three wait states at pc=5
        slow_addr = 28'd5; slow_left = 3;
        run_until_addr(28'd5);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t2_wait", {valid_fe, instruction, imem_addr}, {1'b0, 32'h0, 28'd5});
        end
        cycle();
        chk("t2_instr5", {valid_fe, pc_fe_de, instruction}, {1'b1, 28'd5, memf(28'd5)});

        // 3: stall across an ack at pc=8
        run_until_addr(28'd8);
        stall_en = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t3_hold", {imem_req, valid_fe, pc_fe_de}, {1'b0, 1'b1, 28'd7});
        end
        stall_en = 0;
        cycle();
        chk("t3_release", {valid_fe, pc_fe_de, instruction, imem_addr},
            {1'b1, 28'd8, memf(28'd8), 28'd9});
        cycle();
        chk("t3_next", {valid_fe, pc_fe_de}, {1'b1, 28'd9});

        // 4: jump while 0x10 outstanding, then jump masked by stall
        slow_addr = 28'h10; slow_left = 2;
        run_until_addr(28'h10);
        jmp_en = 1; pc_jmp = 28'h40;
        cycle();
        jmp_en = 0;
        chk("t4_redir", {imem_req, imem_addr, valid_fe}, {1'b1, 28'h10, 1'b0});
        cycle();
        chk("t4_discard", {imem_req, imem_addr, valid_fe}, {1'b1, 28'h10, 1'b0});
        cycle();
        chk("t4_newaddr", {imem_req, imem_addr, valid_fe}, {1'b1, 28'h40, 1'b0});
        cycle();
        chk("t4_instr40", {valid_fe, pc_fe_de, instruction}, {1'b1, 28'h40, memf(28'h40)});
        stall_en = 1; jmp_en = 1; pc_jmp = 28'h7;
        cycle();
        chk("t4_jmpstall", {valid_fe, pc_fe_de, imem_req}, {1'b1, 28'h40, 1'b0});
        stall_en = 0; jmp_en = 0;
        cycle();
        chk("t4_ignored", {valid_fe, pc_fe_de}, {1'b1, 28'h41});

        // 5: kill overrides stall
        stall_en = 1; fe_kill = 1; pc_jmp = 28'h1;
        cycle();
        chk("t5_kill", {valid_fe, instruction, imem_req, imem_addr}, {1'b0, 32'h0, 1'b1, 28'h1});
        stall_en = 0; fe_kill = 0;
        cycle();
        chk("t5_instr1", {valid_fe, pc_fe_de, pc_fe}, {1'b1, 28'd1, 28'd2});

        // 6: PC wrap, then async reset with a read outstanding
        jmp_en = 1; pc_jmp = 28'hFFF_FFFF;
        cycle();
        jmp_en = 0;
        slow_addr = 28'd0; slow_left = 10;
        cycle();
        chk("t6_wrap", {valid_fe, pc_fe_de, pc_fe, imem_addr},
            {1'b1, 28'hFFF_FFFF, 28'd0, 28'd0});
        #2 arst = 1;
        #1;
        chk("t6_arst", {imem_req, imem_addr, instruction, pc_fe, pc_fe_de, valid_fe}, 0);
        @(posedge clk);
        #1;
        arst = 0; slow_left = 0; exp_pc = '0;
        mem_drive();
        cycle();
        chk("t6_reboot", {imem_req, imem_addr, valid_fe}, {1'b1, 28'd0, 1'b0});
        cycle();
        chk("t6_first", {valid_fe, pc_fe_de}, {1'b1, 28'd0});

        // Randomized traffic checked by the stream model
        rand_mode = 1;
        deliveries = 0;
        for (int i = 0; i < 1500; i++) begin
            stall_en = ($urandom_range(0, 99) < 30);
            jmp_en   = ($urandom_range(0, 99) < 6);
            fe_kill  = ($urandom_range(0, 99) < 3);
            pc_jmp   = ($urandom_range(0, 3) == 0) ? (28'hFFF_FFFF - 28'($urandom_range(0, 3)))
                                                   : 28'($urandom);
            cycle();
        end
        stall_en = 0; jmp_en = 0; fe_kill = 0;
        chk("rand_progress", deliveries > 100, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
